// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes,
// decoded opcode/funct values and ALU operation codes.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF  = 5'd0,
        S_ID  = 5'd1,
        S_MA  = 5'd2,
        S_MRD = 5'd3,
        S_LWB = 5'd4,
        S_MWR = 5'd5,
        S_EXR = 5'd6,
        S_RWB = 5'd7,
        S_BR  = 5'd8,
        S_EXI = 5'd9,
        S_IWB = 5'd10,
        S_LUI = 5'd11,
        S_J   = 5'd12,
        S_JAL = 5'd13,
        S_JR  = 5'd14
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags whether
// the funct is one of the supported ALU R-type instructions (jr excluded).
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_rtype_alu
);

    // funct -> ALU operation lookup
    always_comb begin
        o_alu_op    = ALU_ADD;
        o_rtype_alu = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_op = ALU_ADD;
            FN_SUB:  o_alu_op = ALU_SUB;
            FN_AND:  o_alu_op = ALU_AND;
            FN_OR:   o_alu_op = ALU_OR;
            FN_XOR:  o_alu_op = ALU_XOR;
            FN_NOR:  o_alu_op = ALU_NOR;
            FN_SLT:  o_alu_op = ALU_SLT;
            FN_SRL:  o_alu_op = ALU_SRL;
            default: o_rtype_alu = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for the multicycle MIPS datapath. Sequences one
// instruction at a time; all datapath controls derive from the state,
// with Inst only steering ALU_operation and Branch.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        zero,
    input  logic        MIO_ready,
    output logic        IorD,
    output logic        IRWrite,
    output logic [1:0]  RegDst,
    output logic        RegWrite,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [2:0]  ALU_operation,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        illegal,
    output logic [4:0]  state_out
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [2:0] w_funct_op;
    logic       w_rtype_alu;
    logic       w_unused;

    assign w_opcode  = Inst[31:26];
    assign w_funct   = Inst[5:0];
    assign state_out = r_state;

    // zero and the register/immediate fields are consumed by the datapath only
    assign w_unused = &{1'b0, zero, Inst[25:6]};

    alu_dec u_alu_dec (
        .i_funct     (w_funct),
        .o_alu_op    (w_funct_op),
        .o_rtype_alu (w_rtype_alu)
    );

    // State register; reset forces IF even during a memory wait
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state control outputs
    always_comb begin
        w_next        = S_IF;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 2'd0;
        RegWrite      = 1'b0;
        MemtoReg      = 2'd0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'd0;
        PCSource      = 2'd0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        ALU_operation = 3'b000;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        illegal       = 1'b0;
        case (r_state)
            S_IF: begin
                MemRead       = 1'b1;
                IRWrite       = 1'b1;
                ALUSrcB       = 2'd1;
                ALU_operation = ALU_ADD;
                PCWrite       = 1'b1;
                w_next        = MIO_ready ? S_ID : S_IF;
            end
            S_ID: begin
                ALUSrcB       = 2'd3;
                ALU_operation = ALU_ADD;
                case (w_opcode)
                    OP_R: begin
                        if (w_rtype_alu) begin
                            w_next = S_EXR;
                        end else if (w_funct == FN_JR) begin
                            w_next = S_JR;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW:     w_next = S_MA;
                    OP_BEQ, OP_BNE:   w_next = S_BR;
                    OP_ADDI, OP_SLTI: w_next = S_EXI;
                    OP_LUI:           w_next = S_LUI;
                    OP_J:             w_next = S_J;
                    OP_JAL:           w_next = S_JAL;
                    default:          illegal = 1'b1;
                endcase
            end
            S_MA: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'd2;
                ALU_operation = ALU_ADD;
                w_next        = (w_opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                w_next  = MIO_ready ? S_LWB : S_MRD;
            end
            S_LWB: begin
                MemtoReg = 2'd1;
                RegWrite = 1'b1;
            end
            S_MWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next   = MIO_ready ? S_IF : S_MWR;
            end
            S_EXR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = w_funct_op;
                w_next        = S_RWB;
            end
            S_RWB: begin
                RegDst   = 2'd1;
                RegWrite = 1'b1;
            end
            S_BR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 2'd1;
                Branch        = (w_opcode == OP_BEQ);
            end
            S_EXI: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'd2;
                ALU_operation = (w_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                w_next        = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            S_LUI: begin
                MemtoReg = 2'd2;
                RegWrite = 1'b1;
            end
            S_J: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
            end
            S_JAL: begin
                RegDst   = 2'd2;
                MemtoReg = 2'd3;
                RegWrite = 1'b1;
                PCSource = 2'd2;
                PCWrite  = 1'b1;
            end
            S_JR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_OR;
                PCWrite       = 1'b1;
            end
            default: w_next = S_IF;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction-level reference model
// (per-class state paths, per-state control table, cycle budgets) driven
// by directed cases and randomized instructions, stalls and resets.
module tb_mc_ctrl_fsm;

    localparam int C_LW  = 0;
    localparam int C_SW  = 1;
    localparam int C_R   = 2;
    localparam int C_JR  = 3;
    localparam int C_BR  = 4;
    localparam int C_IMM = 5;
    localparam int C_LUI = 6;
    localparam int C_J   = 7;
    localparam int C_JAL = 8;
    localparam int C_ILL = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Inst = '0;
    logic        zero = 1'b0;
    logic        MIO_ready = 1'b1;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
    logic        MemRead, MemWrite, illegal;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic [4:0]  state_out;
    logic [20:0] w_dut_ctrl;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          m_state = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .Inst          (Inst),
        .zero          (zero),
        .MIO_ready     (MIO_ready),
        .IorD          (IorD),
        .IRWrite       (IRWrite),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .MemtoReg      (MemtoReg),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .PCSource      (PCSource),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .Branch        (Branch),
        .ALU_operation (ALU_operation),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .illegal       (illegal),
        .state_out     (state_out)
    );

    assign w_dut_ctrl = {IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
                         PCSource, PCWrite, PCWriteCond, Branch, ALU_operation,
                         MemRead, MemWrite, illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02: return C_R;
                    6'h08:   return C_JR;
                    default: return C_ILL;
                endcase
            end
            6'h23:        return C_LW;
            6'h2B:        return C_SW;
            6'h04, 6'h05: return C_BR;
            6'h08, 6'h0A: return C_IMM;
            6'h0F:        return C_LUI;
            6'h02:        return C_J;
            6'h03:        return C_JAL;
            default:      return C_ILL;
        endcase
    endfunction

    // Total cycles from IF entry back to IF with memory always ready
    function automatic int base_cycles(input int cls);
        case (cls)
            C_LW:                  return 5;
            C_SW, C_R, C_IMM:      return 4;
            C_ILL:                 return 2;
            default:               return 3;
        endcase
    endfunction

    // Expected control vector for a state, in the order of w_dut_ctrl
    function automatic logic [20:0] exp_ctrl(input int st, input logic [31:0] ins);
        logic       iord, irw, rw, asa, pcw, pcwc, br, mr, mw, ill;
        logic [1:0] rd, m2r, asb, pcs;
        logic [2:0] op;
        iord = 0; irw = 0; rw = 0; asa = 0; pcw = 0; pcwc = 0; br = 0;
        mr = 0; mw = 0; ill = 0; rd = 0; m2r = 0; asb = 0; pcs = 0; op = 0;
        case (st)
            0:  begin mr = 1; irw = 1; asb = 1; op = 3'b010; pcw = 1; end
            1:  begin asb = 3; op = 3'b010; ill = (classify(ins) == C_ILL); end
            2:  begin asa = 1; asb = 2; op = 3'b010; end
            3:  begin iord = 1; mr = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin
                    asa = 1;
                    case (ins[5:0])
                        6'h20:   op = 3'b010;
                        6'h22:   op = 3'b110;
                        6'h24:   op = 3'b000;
                        6'h25:   op = 3'b001;
                        6'h26:   op = 3'b011;
                        6'h27:   op = 3'b100;
                        6'h2A:   op = 3'b111;
                        default: op = 3'b101;
                    endcase
                end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; op = 3'b110; pcwc = 1; pcs = 1; br = (ins[31:26] == 6'h04); end
            9:  begin asa = 1; asb = 2; op = (ins[31:26] == 6'h0A) ? 3'b111 : 3'b010; end
            10: begin rw = 1; end
            11: begin m2r = 2; rw = 1; end
            12: begin pcs = 2; pcw = 1; end
            13: begin rd = 2; m2r = 3; rw = 1; pcs = 2; pcw = 1; end
            14: begin asa = 1; op = 3'b001; pcw = 1; end
            default: ;
        endcase
        return {iord, irw, rd, rw, m2r, asa, asb, pcs, pcw, pcwc, br, op, mr, mw, ill};
    endfunction

    function automatic logic [31:0] gen_inst(input int cls);
        logic [31:0] r;
        int          tries;
        r = $urandom;
        case (cls)
            C_R: begin
                r[31:26] = 6'h00;
                case ($urandom_range(7))
                    0: r[5:0] = 6'h20;
                    1: r[5:0] = 6'h22;
                    2: r[5:0] = 6'h24;
                    3: r[5:0] = 6'h25;
                    4: r[5:0] = 6'h26;
                    5: r[5:0] = 6'h27;
                    6: r[5:0] = 6'h2A;
                    default: r[5:0] = 6'h02;
                endcase
            end
            C_JR:  begin r[31:26] = 6'h00; r[20:6] = '0; r[5:0] = 6'h08; end
            C_LW:  r[31:26] = 6'h23;
            C_SW:  r[31:26] = 6'h2B;
            C_BR:  r[31:26] = ($urandom_range(1) == 0) ? 6'h04 : 6'h05;
            C_IMM: r[31:26] = ($urandom_range(1) == 0) ? 6'h08 : 6'h0A;
            C_LUI: r[31:26] = 6'h0F;
            C_J:   r[31:26] = 6'h02;
            C_JAL: r[31:26] = 6'h03;
            default: begin
                tries = 0;
                while (classify(r) != C_ILL && tries < 32) begin
                    r = $urandom;
                    if ($urandom_range(3) == 0) r[31:26] = 6'h00;
                    tries++;
                end
                if (classify(r) != C_ILL) r = 32'hFC000000;
            end
        endcase
        return r;
    endfunction

    // Runs one instruction from IF back to IF against the model.
    // mem_stalls: not-ready cycles forced at the start of MRD/MWR.
    // rst_cycle: 1-based cycle of the instruction on which reset is driven (0 = none).
    task automatic run_instr(input logic [31:0] ins, input int unsigned stall_pct,
                             input int unsigned mem_stalls, input int unsigned rst_cycle);
        int          q[$];
        int          cls;
        int unsigned cyc;
        int unsigned stalls;
        int unsigned mem_left;
        logic        done;
        logic        rst_hit;
        logic        rdy;
        logic        rs;
        cls = classify(ins);
        case (cls)
            C_LW:  q = '{1, 2, 3, 4};
            C_SW:  q = '{1, 2, 5};
            C_R:   q = '{1, 6, 7};
            C_JR:  q = '{1, 14};
            C_BR:  q = '{1, 8};
            C_IMM: q = '{1, 9, 10};
            C_LUI: q = '{1, 11};
            C_J:   q = '{1, 12};
            C_JAL: q = '{1, 13};
            default: q = '{1};
        endcase
        cyc = 0; stalls = 0; mem_left = mem_stalls; done = 0; rst_hit = 0;
        while (!done) begin
            @(negedge clk);
            if (cyc == 0) Inst = ins;
            rs = (rst_cycle != 0) && (cyc + 1 == rst_cycle);
            if ((m_state == 3 || m_state == 5) && mem_left > 0) begin
                rdy = 1'b0;
                mem_left--;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct) || (stalls >= 8);
            end
            MIO_ready = rdy;
            reset     = rs;
            zero      = 1'($urandom_range(1));
            #1;
            chk($sformatf("state@c%0d", cyc), 32'(state_out), 32'(m_state));
            chk($sformatf("ctrl@s%0d", m_state), 32'(w_dut_ctrl), 32'(exp_ctrl(m_state, ins)));
            @(posedge clk);
            cyc++;
            if (rs) begin
                m_state = 0;
                rst_hit = 1;
                done    = 1;
            end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !rdy) begin
                stalls++;
            end else if (q.size() == 0) begin
                m_state = 0;
                done    = 1;
            end else begin
                m_state = q.pop_front();
            end
        end
        if (!rst_hit) begin
            chk($sformatf("cycles %08h", ins), 32'(cyc), 32'(base_cycles(cls) + int'(stalls)));
        end
    endtask

    initial begin
        reset     = 1'b1;
        MIO_ready = 1'b1;
        Inst      = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_ctrl", 32'(w_dut_ctrl), 32'(exp_ctrl(0, Inst)));
        m_state = 0;

        run_instr(32'h012A4020, 0, 0, 0);   // add
        run_instr(32'h8D280004, 0, 2, 0);   // lw, two MRD wait cycles
        run_instr(32'h15090003, 0, 0, 0);   // bne
        run_instr(32'h11090003, 0, 0, 0);   // beq
        run_instr(32'h0C000010, 0, 0, 0);   // jal
        run_instr(32'hFC000000, 0, 0, 0);   // illegal
        run_instr(32'h01200008, 0, 0, 0);   // jr
        run_instr(32'hAD280004, 0, 5, 5);   // sw, reset mid-MWR wait
        run_instr(32'h3C081234, 0, 0, 0);   // lui after reset

        for (int i = 0; i < 400; i++) begin
            int          cls;
            int unsigned rc;
            cls = int'($urandom_range(9));
            rc  = ($urandom_range(19) == 0) ? $urandom_range(1, 5) : 0;
            run_instr(gen_inst(cls), 25, $urandom_range(2), rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
